// File: rtl/router_pkt_fifo.sv
// Per-destination packet FIFO for the router datapath.
// Each entry holds a data byte plus a header (lfd) flag. The read side tracks
// how many bytes of the current packet are still owed, using the length field
// of the stored header. It flags header bytes, the parity byte that ends a
// packet, and headers that arrive before the previous packet is complete.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  localparam int LEN_W    = DATA_W - 2,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              sop_out,
  output logic              pkt_done,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  level,
  output logic              ovf_err,
  output logic              len_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REM_W = LEN_W + 1;

  // Entry layout: bit DATA_W is the header flag, the lower bits are the byte.
  logic [DATA_W:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]  level_reg;
  logic [CNT_W-1:0]  level_next;
  logic [REM_W-1:0]  rem_reg;
  logic [REM_W-1:0]  rem_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              sop_out_reg;
  logic              pkt_done_reg;
  logic              pkt_done_next;
  logic              ovf_err_reg;
  logic              len_err_reg;
  logic              len_err_next;

  logic              flush;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W:0]   rd_entry;

  // Either reset source clears all control state on the same edge.
  assign flush = !resetn || soft_reset;

  // Acceptance uses the pre-edge flags: no write into a full FIFO even when a
  // read happens on the same edge, and no fall-through when empty.
  assign full        = (level_reg == CNT_W'(DEPTH));
  assign empty       = (level_reg == '0);
  assign almost_full = (level_reg >= CNT_W'(AF_THRESH));
  assign wr_accept   = write_enb && !full;
  assign rd_accept   = read_enb && !empty;
  assign rd_entry    = mem[rd_ptr_reg];

  // Storage array; contents survive resets, only pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= {lfd_state, data_in};
    end
  end

  // Occupancy next-state from the accepted operations.
  always_comb begin
    level_next = level_reg;
    case ({wr_accept, rd_accept})
      2'b10:   level_next = level_reg + CNT_W'(1);
      2'b01:   level_next = level_reg - CNT_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Packet-length tracking for the byte being read this cycle.
  always_comb begin
    rem_next      = rem_reg;
    pkt_done_next = 1'b0;
    len_err_next  = 1'b0;
    if (rd_accept) begin
      if (rd_entry[DATA_W]) begin
        // New header always wins; an unfinished previous packet is an error.
        len_err_next = (rem_reg != '0);
        rem_next     = {1'b0, rd_entry[DATA_W-1:2]} + REM_W'(1);
      end else if (rem_reg == REM_W'(1)) begin
        rem_next      = '0;
        pkt_done_next = 1'b1;
      end else if (rem_reg != '0) begin
        rem_next = rem_reg - REM_W'(1);
      end
      // Orphan bytes (rem_reg == 0) pass through with no tracking change.
    end
  end

  // Pointer, level and tracking registers.
  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rem_reg    <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
      rem_reg   <= rem_next;
    end
  end

  // Registered read data and status pulses; data holds when nothing is read.
  always_ff @(posedge clock) begin
    if (flush) begin
      data_out_reg <= '0;
      sop_out_reg  <= 1'b0;
      pkt_done_reg <= 1'b0;
      ovf_err_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      if (rd_accept) begin
        data_out_reg <= rd_entry[DATA_W-1:0];
        sop_out_reg  <= rd_entry[DATA_W];
      end
      pkt_done_reg <= pkt_done_next;
      len_err_reg  <= len_err_next;
      ovf_err_reg  <= write_enb && full;
    end
  end

  assign data_out = data_out_reg;
  assign sop_out  = sop_out_reg;
  assign pkt_done = pkt_done_reg;
  assign ovf_err  = ovf_err_reg;
  assign len_err  = len_err_reg;
  assign level    = level_reg;

endmodule
